eth_rx_axis_sink: RTL
=====================

Name: eth_rx_axis_sink

Overview:
- AXI-Stream receive-side sink between the Ethernet RX MAC and the iDMA AXI-Stream read frontend.
- Buffers incoming frame beats in a beat FIFO and counts valid bytes per frame.
- Publishes one length descriptor per completed frame so the iDMA backend can program a stream-to-memory transfer of exactly that size.
- Truncates oversize frames and flags them. Discards the remainder of an oversize frame until its tlast.

Parameters:
- DataWidth, 64, stream data width in bits; StrbWidth = DataWidth/8.
- FifoDepth, 16, beat FIFO depth in beats; power of two, at least 2.
- LenFifoDepth, 4, length descriptor FIFO depth; power of two, at least 2.
- TFLenWidth, 32, width of the byte-length descriptor.
- MaxFrameBytes, 1536, maximum accepted frame size in bytes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- s_tvalid_i  in  1  MAC stream valid
- s_tready_o  out  1  MAC stream ready
- s_tdata_i  in  DataWidth  MAC stream data
- s_tkeep_i  in  StrbWidth  byte enables; contiguous from bit 0
- s_tlast_i  in  1  last beat of frame
- m_tvalid_o  out  1  stream valid toward iDMA
- m_tready_i  in  1  stream ready from iDMA
- m_tdata_o  out  DataWidth  data toward iDMA
- m_tkeep_o  out  StrbWidth  byte enables toward iDMA
- m_tlast_o  out  1  frame end toward iDMA
- len_valid_o  out  1  length descriptor valid
- len_ready_i  in  1  length descriptor accepted
- len_o  out  TFLenWidth  frame byte count
- len_err_o  out  1  frame was truncated (oversize)
- frame_cnt_o  out  16  frames published (stats)
- drop_cnt_o  out  16  beats discarded (stats)

Behaviour:
- Reset: all outputs 0, FSM in RECV, byte counter 0, both FIFOs empty, stats counters 0.
- Clock/reset: one clock, clk_i; reset rst_i is asynchronous, active-high.
- Reset asserted mid-frame: partial frame is lost and no descriptor is issued.
- FSM states:
  - RECV: s_tready_o = !beat_full && !len_full. Both full flags are registered, so there is no combinational path from m_tready_i or len_ready_i to s_tready_o.
  - DROP: s_tready_o = 1. Accepted beats are discarded; drop_cnt increments per beat.
  - DROP -> RECV on an accepted beat with s_tlast_i = 1.
- Byte counting: popcount(s_tkeep_i) is added to the running byte count on every accepted RECV beat. A beat with tkeep = 0 is stored and adds 0.
- Normal frame end: an accepted RECV beat with tlast = 1 and running count <= MaxFrameBytes is stored, and {count, err=0} is pushed to the length FIFO. The counter clears to 0 for the next frame.
- Oversize: an accepted RECV beat that takes the running count above MaxFrameBytes is handled as follows.
  - The beat is stored with m_tlast forced to 1.
  - {running count including this beat, err=1} is pushed to the length FIFO.
  - The counter clears.
  - Next state is DROP, unless that beat already carried tlast; in that case the state stays RECV.
- Latency: a beat accepted in cycle N is visible on m_* in cycle N+1. A descriptor pushed in cycle N is visible on len_* in cycle N+1.
- Handshakes: standard valid/ready on both outputs. m_* and len_* stay stable while valid is high and ready is low.
- FIFO boundaries:
  - Push and pop in the same cycle while full: the pop completes, and the push is blocked by the registered full flag.
  - Push and pop in the same cycle while empty: the push completes and is visible the next cycle.
  - Read and write pointers wrap modulo depth; an extra wrap bit distinguishes full from empty.
- Stream and descriptor ordering: independent handshakes. len_valid_o may precede or follow the frame's last m beat; the consumer pairs descriptors with frames in order.

Optional Feature:
- Macro: ETH_RX_SINK_STATS_EN.
- Defined:
  - frame_cnt_o increments on each length FIFO push.
  - drop_cnt_o increments on each beat discarded in DROP.
  - Both counters are 16-bit and wrap at 0xFFFF -> 0.
- Undefined: frame_cnt_o and drop_cnt_o are tied to 0 and no counter registers are synthesised.

Test Plan:
- 3-beat frame, tkeep FF, FF, 0F, tlast on beat 3; m_tready_i = len_ready_i = 1 -> 3 beats out in order, last with tlast = 1; len_o = 20, len_err_o = 0, one cycle after beat-3 acceptance.
- m_tready_i = 0, push 17 beats (FifoDepth 16) -> s_tready_o drops after the 16th accept; raise m_tready_i -> beat 17 accepted, data order intact.
- 200-beat frame, all tkeep FF (1600 B), MaxFrameBytes 1536 -> 193 beats out, beat 193 with tlast = 1; len_o = 1544, len_err_o = 1; 7 beats dropped (drop_cnt_o = 7 with STATS_EN); next frame received normally.
- len_ready_i = 0, send 5 single-beat frames -> 4 descriptors queued, s_tready_o = 0 afterwards; pulse len_ready_i -> 5th frame accepted; descriptors emerge in order.
- Assert rst_i asynchronously mid-frame after 2 beats -> all outputs 0 immediately; following 1-beat frame with tkeep 01 -> len_o = 1.
- Single beat, tkeep 00, tlast = 1 -> beat forwarded, len_o = 0, len_err_o = 0.

Source files
------------

// File: rtl/eth_rx_axis_sink.sv
// ---------------------------------------------------------------------------
// eth_rx_axis_sink
// Receive-side AXI-Stream sink between the Ethernet RX MAC and the iDMA
// stream frontend. Frame beats are buffered in a beat FIFO. Valid bytes are
// counted per frame, and one {length, err} descriptor is published per
// completed frame. Frames longer than MaxFrameBytes are truncated: the
// overflowing beat is stored with tlast forced and err set, and the rest of
// the frame is discarded up to its tlast.
//
// Optional build macro: ETH_RX_SINK_STATS_EN enables the frame_cnt_o and
// drop_cnt_o statistics counters. When the macro is undefined, both outputs
// are tied to zero.
//
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   s_tvalid_i/s_tready_o/s_tdata_i/
//   s_tkeep_i/s_tlast_i                stream from the MAC
//   m_tvalid_o/m_tready_i/m_tdata_o/
//   m_tkeep_o/m_tlast_o                stream toward the iDMA
//   len_valid_o/len_ready_i/len_o/
//   len_err_o                          per-frame length descriptor
//   frame_cnt_o, drop_cnt_o            statistics (wrap at 16 bits)
// ---------------------------------------------------------------------------
module eth_rx_axis_sink #(
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned StrbWidth     = DataWidth / 8,
    parameter int unsigned FifoDepth     = 16,
    parameter int unsigned LenFifoDepth  = 4,
    parameter int unsigned TFLenWidth    = 32,
    parameter int unsigned MaxFrameBytes = 1536
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_tvalid_i,
    output logic                  s_tready_o,
    input  logic [DataWidth-1:0]  s_tdata_i,
    input  logic [StrbWidth-1:0]  s_tkeep_i,
    input  logic                  s_tlast_i,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic [DataWidth-1:0]  m_tdata_o,
    output logic [StrbWidth-1:0]  m_tkeep_o,
    output logic                  m_tlast_o,
    output logic                  len_valid_o,
    input  logic                  len_ready_i,
    output logic [TFLenWidth-1:0] len_o,
    output logic                  len_err_o,
    output logic [15:0]           frame_cnt_o,
    output logic [15:0]           drop_cnt_o
);

    localparam int unsigned BeatAw   = $clog2(FifoDepth);
    localparam int unsigned LenAw    = $clog2(LenFifoDepth);
    localparam int unsigned KeepCntW = $clog2(StrbWidth + 1);
    localparam int unsigned BeatW    = DataWidth + StrbWidth + 1;
    localparam int unsigned LenEntW  = TFLenWidth + 1;

    typedef enum logic {
        RECV = 1'b0,
        DROP = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    s_tready_q, s_tready_d;
    logic [TFLenWidth-1:0]   byte_cnt_q, byte_cnt_d;

    logic [BeatW-1:0]        beat_mem_q [FifoDepth];
    logic [BeatAw:0]         beat_wr_q, beat_wr_d, beat_rd_q, beat_rd_d;
    logic                    beat_full_q, beat_full_d, beat_empty_q, beat_empty_d;
    logic                    beat_push, beat_pop;
    logic [BeatW-1:0]        beat_wdata;

    logic [LenEntW-1:0]      len_mem_q [LenFifoDepth];
    logic [LenAw:0]          len_wr_q, len_wr_d, len_rd_q, len_rd_d;
    logic                    len_full_q, len_full_d, len_empty_q, len_empty_d;
    logic                    len_push, len_pop;
    logic [LenEntW-1:0]      len_wdata;

    logic                    s_hs;
    logic [KeepCntW-1:0]     keep_cnt;
    logic [TFLenWidth-1:0]   byte_sum;
    logic                    oversize;

    assign s_hs = s_tvalid_i && s_tready_q;

    // Number of valid bytes in the incoming beat.
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < int'(StrbWidth); i++) begin
            keep_cnt = keep_cnt + KeepCntW'(s_tkeep_i[i]);
        end
    end

    // Frame FSM: byte counting, descriptor generation, oversize truncation.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        beat_push  = 1'b0;
        len_push   = 1'b0;
        byte_sum   = byte_cnt_q + TFLenWidth'(keep_cnt);
        oversize   = byte_sum > TFLenWidth'(MaxFrameBytes);
        // An oversize beat closes the frame toward the iDMA.
        beat_wdata = {s_tdata_i, s_tkeep_i, s_tlast_i | oversize};
        len_wdata  = {byte_sum, oversize};

        case (state_q)
            RECV: begin
                if (s_hs) begin
                    beat_push  = 1'b1;
                    byte_cnt_d = byte_sum;
                    if (oversize) begin
                        len_push   = 1'b1;
                        byte_cnt_d = '0;
                        if (!s_tlast_i) begin
                            state_d = DROP;
                        end
                    end else if (s_tlast_i) begin
                        len_push   = 1'b1;
                        byte_cnt_d = '0;
                    end
                end
            end
            DROP: begin
                if (s_hs && s_tlast_i) begin
                    state_d = RECV;
                end
            end
        endcase
    end

    // FIFO pointer arithmetic; the extra MSB separates full from empty.
    always_comb begin
        beat_pop     = !beat_empty_q && m_tready_i;
        beat_wr_d    = beat_wr_q + (BeatAw + 1)'(beat_push);
        beat_rd_d    = beat_rd_q + (BeatAw + 1)'(beat_pop);
        beat_empty_d = (beat_wr_d == beat_rd_d);
        beat_full_d  = (beat_wr_d[BeatAw] != beat_rd_d[BeatAw]) &&
                       (beat_wr_d[BeatAw-1:0] == beat_rd_d[BeatAw-1:0]);

        len_pop      = !len_empty_q && len_ready_i;
        len_wr_d     = len_wr_q + (LenAw + 1)'(len_push);
        len_rd_d     = len_rd_q + (LenAw + 1)'(len_pop);
        len_empty_d  = (len_wr_d == len_rd_d);
        len_full_d   = (len_wr_d[LenAw] != len_rd_d[LenAw]) &&
                       (len_wr_d[LenAw-1:0] == len_rd_d[LenAw-1:0]);

        // Ready is registered from next-cycle flags: no path from the consumers.
        s_tready_d   = (state_d == DROP) || (!beat_full_d && !len_full_d);
    end

    // Control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RECV;
            s_tready_q   <= 1'b0;
            byte_cnt_q   <= '0;
            beat_wr_q    <= '0;
            beat_rd_q    <= '0;
            beat_full_q  <= 1'b0;
            beat_empty_q <= 1'b1;
            len_wr_q     <= '0;
            len_rd_q     <= '0;
            len_full_q   <= 1'b0;
            len_empty_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            s_tready_q   <= s_tready_d;
            byte_cnt_q   <= byte_cnt_d;
            beat_wr_q    <= beat_wr_d;
            beat_rd_q    <= beat_rd_d;
            beat_full_q  <= beat_full_d;
            beat_empty_q <= beat_empty_d;
            len_wr_q     <= len_wr_d;
            len_rd_q     <= len_rd_d;
            len_full_q   <= len_full_d;
            len_empty_q  <= len_empty_d;
        end
    end

    // Beat FIFO storage, cleared so outputs read zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                beat_mem_q[i] <= '0;
            end
        end else if (beat_push) begin
            beat_mem_q[beat_wr_q[BeatAw-1:0]] <= beat_wdata;
        end
    end

    // Length descriptor FIFO storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(LenFifoDepth); i++) begin
                len_mem_q[i] <= '0;
            end
        end else if (len_push) begin
            len_mem_q[len_wr_q[LenAw-1:0]] <= len_wdata;
        end
    end

    assign s_tready_o                         = s_tready_q;
    assign m_tvalid_o                         = !beat_empty_q;
    assign {m_tdata_o, m_tkeep_o, m_tlast_o}  = beat_mem_q[beat_rd_q[BeatAw-1:0]];
    assign len_valid_o                        = !len_empty_q;
    assign {len_o, len_err_o}                 = len_mem_q[len_rd_q[LenAw-1:0]];

`ifdef ETH_RX_SINK_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Statistics: descriptors published and beats discarded in DROP.
    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(len_push);
        drop_cnt_d  = drop_cnt_q + 16'(s_hs && (state_q == DROP));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign drop_cnt_o  = '0;
`endif

endmodule
